// File: rtl/excp_pkg.sv
// Shared constants for the exception sequencer: ExcCodes, exception_type bit
// positions, CP0 Status/Cause field positions and FSM state encodings.
package excp_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ET_ADEL_IF = 31;
  localparam int ET_RI      = 30;
  localparam int ET_OV      = 29;
  localparam int ET_BP      = 28;
  localparam int ET_SYS     = 27;
  localparam int ET_ADEL_LD = 26;
  localparam int ET_ADES    = 25;
  localparam int ET_ERET    = 0;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_HI = 15;
  localparam int ST_IM_LO = 8;
  localparam int CA_IP_HI = 15;
  localparam int CA_IP_LO = 8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  typedef enum logic {
    BADV_PC   = 1'b0,
    BADV_ADDR = 1'b1
  } badv_sel_e;

  function automatic logic irq_pending(input logic ie, input logic exl,
                                       input logic [7:0] im, input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

endpackage

// File: rtl/excp_ctrl_if.sv
// CP0 commit command and fetch redirect handshake leaving the sequencer.
interface excp_ctrl_if;
  logic        commit_o;
  logic        commit_eret_o;
  logic [4:0]  commit_code_o;
  logic [31:0] commit_epc_o;
  logic        commit_bd_o;
  logic        commit_epc_we_o;
  logic        commit_badv_we_o;
  logic [31:0] commit_badv_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  modport master (
    output commit_o, commit_eret_o, commit_code_o, commit_epc_o, commit_bd_o,
           commit_epc_we_o, commit_badv_we_o, commit_badv_o,
           redirect_valid_o, redirect_pc_o,
    input  redirect_ready_i
  );

  modport slave (
    input  commit_o, commit_eret_o, commit_code_o, commit_epc_o, commit_bd_o,
           commit_epc_we_o, commit_badv_we_o, commit_badv_o,
           redirect_valid_o, redirect_pc_o,
    output redirect_ready_i
  );
endinterface

// File: rtl/excp_prio_enc.sv
// Combinational priority encoder: interrupt, then synchronous exceptions in
// table order, then ERET.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic        irq,
  input  logic [31:0] exc_type,
  output logic        hit,
  output logic        eret,
  output logic [4:0]  code,
  output logic        badv_we,
  output badv_sel_e   badv_sel
);

  localparam int SYNC_N = 7;

  // Index 0 is the highest-priority synchronous exception.
  localparam int SYNC_BIT [SYNC_N] = '{ET_ADEL_IF, ET_RI, ET_OV, ET_BP,
                                       ET_SYS, ET_ADEL_LD, ET_ADES};
  localparam logic [4:0] SYNC_CODE [SYNC_N] = '{EXC_ADEL, EXC_RI, EXC_OV, EXC_BP,
                                                EXC_SYS, EXC_ADEL, EXC_ADES};
  localparam logic SYNC_BADV [SYNC_N] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam badv_sel_e SYNC_SEL [SYNC_N] = '{BADV_PC, BADV_PC, BADV_PC, BADV_PC,
                                              BADV_PC, BADV_ADDR, BADV_ADDR};

  logic [SYNC_N-1:0] sync_req;
  logic              unused_bits;

  for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_req
    assign sync_req[gi] = exc_type[SYNC_BIT[gi]];
  end

  assign unused_bits = ^exc_type[24:1];

  always_comb begin
    hit      = 1'b0;
    eret     = 1'b0;
    code     = EXC_INT;
    badv_we  = 1'b0;
    badv_sel = BADV_PC;
    if (irq) begin
      hit = 1'b1;
    end else if (|sync_req) begin
      hit = 1'b1;
      // Walk from lowest to highest priority so the highest set bit wins.
      for (int i = SYNC_N - 1; i >= 0; i--) begin
        if (sync_req[i]) begin
          code     = SYNC_CODE[i];
          badv_we  = SYNC_BADV[i];
          badv_sel = SYNC_SEL[i];
        end
      end
    end else if (exc_type[ET_ERET]) begin
      hit  = 1'b1;
      eret = 1'b1;
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt sequencer: accepts one event from MEM, issues a single
// CP0 commit, flushes for FLUSH_CYCLES, then hands the redirect PC to fetch.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         mem_valid_i,
  input  logic         stall_i,
  input  logic [31:0]  exception_type_i,
  input  logic [31:0]  pc_i,
  input  logic [31:0]  exception_addr_i,
  input  logic         in_delayslot_i,
  input  logic [31:0]  cp0_status_i,
  input  logic [31:0]  cp0_cause_i,
  input  logic [31:0]  cp0_epc_i,
  excp_ctrl_if.master  cmd,
  output logic         flush_o,
  output logic         busy_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("excp_ctrl: FLUSH_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        commit_reg;
  logic        eret_reg;
  logic [4:0]  code_reg;
  logic [31:0] epc_reg;
  logic        bd_reg;
  logic        epc_we_reg;
  logic        badv_we_reg;
  logic [31:0] badv_reg;
  logic [31:0] rpc_reg;

  logic        irq;
  logic        enc_hit;
  logic        enc_eret;
  logic [4:0]  enc_code;
  logic        enc_badv_we;
  badv_sel_e   enc_badv_sel;
  logic        accept;
  logic        unused_cp0;

  assign irq = irq_pending(cp0_status_i[ST_IE], cp0_status_i[ST_EXL],
                           cp0_status_i[ST_IM_HI:ST_IM_LO],
                           cp0_cause_i[CA_IP_HI:CA_IP_LO]);

  assign unused_cp0 = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

  excp_prio_enc u_prio_enc (
    .irq      (irq),
    .exc_type (exception_type_i),
    .hit      (enc_hit),
    .eret     (enc_eret),
    .code     (enc_code),
    .badv_we  (enc_badv_we),
    .badv_sel (enc_badv_sel)
  );

  assign accept = (state_reg == S_IDLE) & mem_valid_i & ~stall_i & enc_hit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_FLUSH;
          cnt_next   = CNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_REDIRECT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_REDIRECT: begin
        if (cmd.redirect_ready_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      commit_reg  <= 1'b0;
      eret_reg    <= 1'b0;
      code_reg    <= 5'd0;
      epc_reg     <= 32'd0;
      bd_reg      <= 1'b0;
      epc_we_reg  <= 1'b0;
      badv_we_reg <= 1'b0;
      badv_reg    <= 32'd0;
      rpc_reg     <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      commit_reg <= accept;
      if (accept) begin
        eret_reg    <= enc_eret;
        code_reg    <= enc_code;
        // The MEM instruction is not retired, so EPC points at it (or its branch).
        bd_reg      <= in_delayslot_i;
        epc_reg     <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        epc_we_reg  <= ~cp0_status_i[ST_EXL];
        badv_we_reg <= enc_badv_we;
        badv_reg    <= !enc_badv_we ? 32'd0 :
                       (enc_badv_sel == BADV_PC) ? pc_i : exception_addr_i;
        rpc_reg     <= enc_eret ? cp0_epc_i : EXC_VECTOR;
      end
    end
  end

  assign cmd.commit_o         = commit_reg;
  assign cmd.commit_eret_o    = eret_reg;
  assign cmd.commit_code_o    = code_reg;
  assign cmd.commit_epc_o     = epc_reg;
  assign cmd.commit_bd_o      = bd_reg;
  assign cmd.commit_epc_we_o  = epc_we_reg;
  assign cmd.commit_badv_we_o = badv_we_reg;
  assign cmd.commit_badv_o    = badv_reg;
  assign cmd.redirect_valid_o = (state_reg == S_REDIRECT);
  assign cmd.redirect_pc_o    = rpc_reg;

  assign flush_o = (state_reg == S_FLUSH);
  assign busy_o  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: a reference model pushes expected commits and
// redirects, a negedge monitor pops and compares them against the DUT.
module tb_excp_ctrl;

  localparam int          F   = 2;
  localparam logic [31:0] VEC = 32'hbfc0_0380;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        mem_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] et = '0;
  logic [31:0] pc = '0;
  logic [31:0] addr = '0;
  logic        ds = 1'b0;
  logic [31:0] st = '0;
  logic [31:0] ca = '0;
  logic [31:0] epc_in = '0;
  logic        rdy = 1'b0;
  logic        flush_o, busy_o;

  excp_ctrl_if bus ();
  assign bus.redirect_ready_i = rdy;

  excp_ctrl #(.FLUSH_CYCLES(F), .EXC_VECTOR(VEC)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .mem_valid_i      (mem_valid),
    .stall_i          (stall),
    .exception_type_i (et),
    .pc_i             (pc),
    .exception_addr_i (addr),
    .in_delayslot_i   (ds),
    .cp0_status_i     (st),
    .cp0_cause_i      (ca),
    .cp0_epc_i        (epc_in),
    .cmd              (bus),
    .flush_o          (flush_o),
    .busy_o           (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        epc_we;
    logic        badv_we;
    logic [31:0] badv;
  } commit_t;

  commit_t     cq[$];
  logic [31:0] rq[$];
  commit_t     last_act;
  logic [31:0] last_rpc = '0;
  int          last_flush = 0;
  int          flush_run = 0;
  int          tests = 0;
  int          fails = 0;
  int          m_phase = 0;   // 0 idle, 1 flushing, 2 waiting for fetch
  int          m_left = 0;
  bit          mon_on = 0;

  int          sb_bit  [7] = '{31, 30, 29, 28, 27, 26, 25};
  logic [4:0]  sb_code [7] = '{5'd4, 5'd10, 5'd12, 5'd9, 5'd8, 5'd4, 5'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: decides acceptance from the documented rules.
  task automatic model_accept();
    commit_t     e;
    logic [31:0] tgt;
    bit          found;
    bit          irq;
    irq   = st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'd0);
    found = 0;
    tgt   = VEC;
    e     = '{eret: 1'b0, code: 5'd0, epc: 32'd0, bd: 1'b0, epc_we: 1'b0,
              badv_we: 1'b0, badv: 32'd0};
    if (irq) begin
      found = 1;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!found && et[sb_bit[i]]) begin
          found  = 1;
          e.code = sb_code[i];
          if (sb_bit[i] == 31) begin
            e.badv_we = 1'b1;
            e.badv    = pc;
          end else if (sb_bit[i] == 26 || sb_bit[i] == 25) begin
            e.badv_we = 1'b1;
            e.badv    = addr;
          end
        end
      end
      if (!found && et[0]) begin
        found  = 1;
        e.eret = 1'b1;
        tgt    = epc_in;
      end
    end
    if (found) begin
      e.bd     = ds;
      e.epc    = ds ? pc - 32'd4 : pc;
      e.epc_we = !st[1];
      cq.push_back(e);
      rq.push_back(tgt);
      m_phase = 1;
      m_left  = F;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock_i);
      if (!reset_i) begin
        m_phase = 0;
        m_left  = 0;
        cq.delete();
        rq.delete();
      end else begin
        case (m_phase)
          0: if (mem_valid && !stall) model_accept();
          1: begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
          default: if (rdy) m_phase = 0;
        endcase
      end
    end
  end

  // Monitor: compares strobes every cycle, pops the scoreboard on commit/handshake.
  initial begin
    commit_t e;
    wait (mon_on);
    forever begin
      @(negedge clock_i);
      chk("flush", flush_o, 32'(m_phase == 1));
      chk("busy", busy_o, 32'(m_phase != 0));
      chk("redirect_valid", bus.redirect_valid_o, 32'(m_phase == 2));
      chk("commit_strobe", bus.commit_o, 32'(m_phase == 1 && m_left == F));
      if (flush_o) flush_run++;
      else if (flush_run > 0) begin
        last_flush = flush_run;
        flush_run  = 0;
      end
      if (bus.commit_o) begin
        last_act = '{eret: bus.commit_eret_o, code: bus.commit_code_o,
                     epc: bus.commit_epc_o, bd: bus.commit_bd_o,
                     epc_we: bus.commit_epc_we_o, badv_we: bus.commit_badv_we_o,
                     badv: bus.commit_badv_o};
        if (cq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_commit: got code %0d expected no commit", bus.commit_code_o);
        end else begin
          e = cq.pop_front();
          chk("commit_eret", bus.commit_eret_o, e.eret);
          chk("commit_epc_we", bus.commit_epc_we_o, e.epc_we);
          chk("commit_badv_we", bus.commit_badv_we_o, e.badv_we);
          if (e.badv_we) chk("commit_badv", bus.commit_badv_o, e.badv);
          if (!e.eret) begin
            chk("commit_code", bus.commit_code_o, e.code);
            chk("commit_epc", bus.commit_epc_o, e.epc);
            chk("commit_bd", bus.commit_bd_o, e.bd);
          end
        end
      end
      if (bus.redirect_valid_o) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_redirect: got %h expected none", bus.redirect_pc_o);
        end else begin
          chk("redirect_pc", bus.redirect_pc_o, rq[0]);
          if (rdy) begin
            last_rpc = bus.redirect_pc_o;
            void'(rq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic quiet();
    mem_valid = 1'b0;
    stall     = 1'b0;
    et        = '0;
  endtask

  task automatic fire(input logic [31:0] t, input logic [31:0] p, input logic [31:0] a,
                      input logic d, input logic [31:0] s, input logic [31:0] c,
                      input logic [31:0] ep);
    et = t; pc = p; addr = a; ds = d; st = s; ca = c; epc_in = ep;
    mem_valid = 1'b1;
    stall     = 1'b0;
    tick();
    quiet();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (busy_o) begin
      fails++;
      $display("FAIL idle_timeout: got busy 1 expected 0 within 200 cycles");
    end
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_flush"}, flush_o, 0);
    chk({tag, "_commit"}, bus.commit_o, 0);
    chk({tag, "_eret"}, bus.commit_eret_o, 0);
    chk({tag, "_code"}, bus.commit_code_o, 0);
    chk({tag, "_epc"}, bus.commit_epc_o, 0);
    chk({tag, "_bd"}, bus.commit_bd_o, 0);
    chk({tag, "_epc_we"}, bus.commit_epc_we_o, 0);
    chk({tag, "_badv_we"}, bus.commit_badv_we_o, 0);
    chk({tag, "_badv"}, bus.commit_badv_o, 0);
    chk({tag, "_rvalid"}, bus.redirect_valid_o, 0);
    chk({tag, "_rpc"}, bus.redirect_pc_o, 0);
  endtask

  initial begin
    logic [31:0] held_pc;
    int          n;
    int          r;

    tick();
    tick();
    chk_all_zero("reset");
    mon_on  = 1;
    reset_i = 1'b1;
    rdy     = 1'b1;
    tick();

    // Overflow, not in a delay slot, EXL=0.
    fire(32'h2000_0000, 32'h8000_0100, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_idle();
    chk("ov_code", last_act.code, 12);
    chk("ov_epc", last_act.epc, 32'h8000_0100);
    chk("ov_bd", last_act.bd, 0);
    chk("ov_epc_we", last_act.epc_we, 1);
    chk("ov_flush_len", last_flush, F);
    chk("ov_redirect", last_rpc, VEC);

    // Load ADEL in a delay slot.
    fire(32'h0400_0000, 32'h8000_0204, 32'h0000_0003, 1'b1, 32'h0, 32'h0, 32'h0);
    wait_idle();
    chk("adel_code", last_act.code, 4);
    chk("adel_epc", last_act.epc, 32'h8000_0200);
    chk("adel_bd", last_act.bd, 1);
    chk("adel_badv", last_act.badv, 32'h0000_0003);

    // ERET with EXL set.
    fire(32'h0000_0001, 32'h8000_0300, 32'h0, 1'b0, 32'h0000_0002, 32'h0, 32'h8000_1000);
    wait_idle();
    chk("eret_flag", last_act.eret, 1);
    chk("eret_epc_we", last_act.epc_we, 0);
    chk("eret_redirect", last_rpc, 32'h8000_1000);

    // Interrupt beats a concurrent RI.
    fire(32'h4000_0000, 32'h8000_0400, 32'h0, 1'b0, 32'h0000_8001, 32'h0000_8000, 32'h0);
    wait_idle();
    chk("irq_code", last_act.code, 0);
    chk("irq_redirect", last_rpc, VEC);

    // EXL=1 masks the interrupt: no accept.
    et = '0; st = 32'h0000_8003; ca = 32'h0000_8000; mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("irq_masked_busy", busy_o, 0);
    end
    quiet();
    st = '0;
    ca = '0;

    // Fetch back-pressure: redirect stays stable and new events are ignored.
    rdy = 1'b0;
    fire(32'h1000_0000, 32'h8000_0500, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    n = 0;
    while (!bus.redirect_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("hold_reached_redirect", bus.redirect_valid_o, 1);
    held_pc = bus.redirect_pc_o;
    et = 32'h0800_0000; pc = 32'h8000_0600; mem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", bus.redirect_valid_o, 1);
      chk("hold_pc", bus.redirect_pc_o, held_pc);
    end
    quiet();
    rdy = 1'b1;
    wait_idle();
    chk("hold_redirect", last_rpc, VEC);

    // Reset during the second flush cycle.
    fire(32'h0800_0000, 32'h8000_0700, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    reset_i = 1'b0;
    tick();
    chk_all_zero("midreset");
    reset_i = 1'b1;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      mem_valid = ($urandom_range(0, 9) < 8);
      stall     = ($urandom_range(0, 9) < 2);
      rdy       = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r < 5) et = '0;
      else if (r < 8) et = 32'h1 << sb_bit[$urandom_range(0, 6)];
      else if (r == 8) et = 32'h1;
      else et = ($urandom & 32'hFE00_0001) | ($urandom & 32'h01FF_FFFE);
      pc     = $urandom & 32'hFFFF_FFFC;
      addr   = $urandom;
      ds     = $urandom_range(0, 1);
      st     = {16'h0, 8'($urandom), 6'h0, 1'($urandom), 1'($urandom)};
      ca     = {16'h0, 8'($urandom), 8'h0};
      epc_in = $urandom;
      tick();
    end
    quiet();
    rdy = 1'b1;
    wait_idle();
    chk("scoreboard_commit_empty", cq.size(), 0);
    chk("scoreboard_redirect_empty", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
